// File: rtl/extend_shift_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : extend_shift_unit_if
// Description : Request/response bundle for the extend/shift unit. The slave
//               side belongs to the unit. The master side belongs to whatever
//               issues requests and collects results.
// Revision    : 1.0 - initial release
// ============================================================================
interface extend_shift_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       mode;
    logic [23:0]      instr;
    logic [WIDTH-1:0] rm_val;
    logic [7:0]       rs_val;
    logic             carry_in;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             illegal;

    modport slave (
        input  start, mode, instr, rm_val, rs_val, carry_in,
        output busy, result_valid, result, carry_out, illegal
    );

    modport master (
        output start, mode, instr, rm_val, rs_val, carry_in,
        input  busy, result_valid, result, carry_out, illegal
    );
endinterface
`default_nettype wire

// File: rtl/extend_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : extend_shift_unit
// Description : Execute-stage operand former. It handles rotated immediates,
//               12-bit offsets, branch offsets and register operands shifted
//               by an immediate or a register amount. Shifts are performed
//               iteratively, at most STEP positions per cycle.
//               Optional macro EXTEND_CARRY_EN builds the ARM shifter
//               carry-out. When that macro is undefined, carry_out is tied
//               to 0 and carry_in is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module extend_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    extend_shift_unit_if.slave bus
);
    localparam int LW = $clog2(WIDTH);
    localparam int RW = LW + 1;

    localparam logic [RW-1:0] c_width_amt = RW'(WIDTH);
    localparam logic [RW-1:0] c_step      = RW'(STEP);
    localparam logic [RW-1:0] c_one       = RW'(1);
    localparam logic [8:0]    c_width9    = 9'(WIDTH);

    localparam logic [1:0] c_lsl = 2'b00;
    localparam logic [1:0] c_lsr = 2'b01;
    localparam logic [1:0] c_asr = 2'b10;
    localparam logic [1:0] c_ror = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [1:0]       typ_q, typ_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             illegal_q, illegal_d;

    // Load-time decode results
    logic [WIDTH-1:0] w_ld_op;
    logic [1:0]       w_ld_typ;
    logic [RW-1:0]    w_ld_amt;
    logic             w_ld_ill;
    logic [8:0]       w_a;
    logic             w_gen;
    logic             w_cin;

    // Iterative engine results
    logic [RW-1:0]    w_k;
    logic [WIDTH-1:0] w_sh_op;

`ifdef EXTEND_CARRY_EN
    logic             carry_q, carry_d;
    logic             w_ld_c;
    logic             w_sh_c;
    assign w_cin = bus.carry_in;
`else
    // RRX shifts in 0 when carry support is not built
    assign w_cin = 1'b0;
`endif

    // Decode the request into the operand, the shift kind and the residual amount.
    // Saturating cases are finished here and leave no residual amount.
    always_comb begin
        w_ld_op  = '0;
        w_ld_typ = c_lsl;
        w_ld_amt = '0;
        w_ld_ill = 1'b0;
        w_a      = '0;
        w_gen    = 1'b0;
`ifdef EXTEND_CARRY_EN
        w_ld_c   = w_cin;
`endif
        case (bus.mode)
            3'b000: begin
                // The engine's ROR carry equals the result MSB, as the mode requires
                w_ld_op  = WIDTH'(bus.instr[7:0]);
                w_ld_typ = c_ror;
                w_ld_amt = RW'({bus.instr[11:8], 1'b0});
            end
            3'b001: w_ld_op = WIDTH'(bus.instr[11:0]);
            3'b010: w_ld_op = {{(WIDTH-26){bus.instr[23]}}, bus.instr, 2'b00};
            3'b011: begin
                w_ld_op  = bus.rm_val;
                w_ld_typ = bus.instr[6:5];
                if (bus.instr[11:7] == 5'd0) begin
                    case (bus.instr[6:5])
                        c_lsr, c_asr: begin
                            w_a   = 9'd32;
                            w_gen = 1'b1;
                        end
                        c_ror: begin
                            w_ld_op = {w_cin, bus.rm_val[WIDTH-1:1]};
`ifdef EXTEND_CARRY_EN
                            w_ld_c  = bus.rm_val[0];
`endif
                        end
                        default: ;
                    endcase
                end else begin
                    w_a   = {4'd0, bus.instr[11:7]};
                    w_gen = 1'b1;
                end
            end
            3'b100: begin
                w_ld_op  = bus.rm_val;
                w_ld_typ = bus.instr[6:5];
                if (bus.rs_val != 8'd0) begin
                    w_a   = {1'b0, bus.rs_val};
                    w_gen = 1'b1;
                end
            end
            default: begin
                w_ld_ill = 1'b1;
`ifdef EXTEND_CARRY_EN
                w_ld_c   = 1'b0;
`endif
            end
        endcase

        if (w_gen) begin
            case (w_ld_typ)
                c_lsl: begin
                    if (w_a >= c_width9) begin
                        w_ld_op = '0;
`ifdef EXTEND_CARRY_EN
                        w_ld_c  = (w_a == c_width9) ? bus.rm_val[0] : 1'b0;
`endif
                    end else begin
                        w_ld_amt = w_a[RW-1:0];
                    end
                end
                c_lsr: begin
                    if (w_a >= c_width9) begin
                        w_ld_op = '0;
`ifdef EXTEND_CARRY_EN
                        w_ld_c  = (w_a == c_width9) ? bus.rm_val[WIDTH-1] : 1'b0;
`endif
                    end else begin
                        w_ld_amt = w_a[RW-1:0];
                    end
                end
                c_asr: begin
                    if (w_a >= c_width9) begin
                        w_ld_op = {WIDTH{bus.rm_val[WIDTH-1]}};
`ifdef EXTEND_CARRY_EN
                        w_ld_c  = bus.rm_val[WIDTH-1];
`endif
                    end else begin
                        w_ld_amt = w_a[RW-1:0];
                    end
                end
                default: begin
                    // A rotate by a nonzero multiple of WIDTH leaves the value
                    // unchanged, and the carry is its MSB
                    if (w_a[LW-1:0] == '0) begin
`ifdef EXTEND_CARRY_EN
                        w_ld_c = bus.rm_val[WIDTH-1];
`endif
                    end else begin
                        w_ld_amt = RW'(w_a[LW-1:0]);
                    end
                end
            endcase
        end
    end

    // One engine step: shift by min(rem, STEP) and capture the last bit shifted out
    always_comb begin
        w_k = (rem_q < c_step) ? rem_q : c_step;
        case (typ_q)
            c_lsl:   w_sh_op = op_q << w_k;
            c_lsr:   w_sh_op = op_q >> w_k;
            c_asr:   w_sh_op = $signed(op_q) >>> w_k;
            default: w_sh_op = (op_q >> w_k) | (op_q << (c_width_amt - w_k));
        endcase
`ifdef EXTEND_CARRY_EN
        // The index is valid whenever w_k >= 1, which always holds in SHIFT
        if (typ_q == c_lsl) begin
            w_sh_c = op_q[LW'(c_width_amt - w_k)];
        end else begin
            w_sh_c = op_q[LW'(w_k - c_one)];
        end
`endif
    end

    // Next state: accept in IDLE/DONE, iterate in SHIFT, publish results on entry to DONE
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        typ_d     = typ_q;
        rem_d     = rem_q;
        result_d  = result_q;
        illegal_d = illegal_q;
`ifdef EXTEND_CARRY_EN
        carry_d   = carry_q;
`endif
        case (state_q)
            S_SHIFT: begin
                op_d  = w_sh_op;
                rem_d = rem_q - w_k;
                if (rem_q <= c_step) begin
                    state_d   = S_DONE;
                    result_d  = w_sh_op;
                    illegal_d = 1'b0;
`ifdef EXTEND_CARRY_EN
                    carry_d   = w_sh_c;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    op_d  = w_ld_op;
                    typ_d = w_ld_typ;
                    rem_d = w_ld_amt;
                    if (w_ld_amt == '0) begin
                        state_d   = S_DONE;
                        result_d  = w_ld_op;
                        illegal_d = w_ld_ill;
`ifdef EXTEND_CARRY_EN
                        carry_d   = w_ld_c;
`endif
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            typ_q     <= c_lsl;
            rem_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
`ifdef EXTEND_CARRY_EN
            carry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            typ_q     <= typ_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
`ifdef EXTEND_CARRY_EN
            carry_q   <= carry_d;
`endif
        end
    end

    assign bus.busy         = (state_q == S_SHIFT);
    assign bus.result_valid = (state_q == S_DONE);
    assign bus.result       = result_q;
    assign bus.illegal      = illegal_q;
`ifdef EXTEND_CARRY_EN
    assign bus.carry_out    = carry_q;
`else
    assign bus.carry_out    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_extend_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_extend_shift_unit
// Description : Scoreboard bench for extend_shift_unit (WIDTH=32, STEP=4).
//               A reference model computes whole-operand results. A monitor
//               checks result, carry, illegal and latency for each valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_extend_shift_unit;
    localparam int W = 32;
    localparam int S = 4;
`ifdef EXTEND_CARRY_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    exp_t q[$];

    extend_shift_unit_if #(.WIDTH(W)) bus ();

    extend_shift_unit #(.WIDTH(W), .STEP(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Whole-operand reference: every shift is done at once on a 64-bit scratch value
    function automatic void model(input logic [2:0] m, input logic [23:0] ins,
                                  input logic [31:0] x, input logic [7:0] rs,
                                  input logic cin_raw, output logic [31:0] res,
                                  output logic c, output logic ill, output int amt);
        logic       cin;
        bit [63:0]  t;
        int         a;
        int         r;
        logic [1:0] ty;
        cin = CE ? cin_raw : 1'b0;
        res = '0; c = cin; ill = 1'b0; amt = 0;
        ty  = ins[6:5];
        case (m)
            3'd0: begin
                a   = 2 * int'(ins[11:8]);
                res = {24'd0, ins[7:0]};
                if (a != 0) begin
                    t   = {res, res} >> a;
                    res = t[31:0];
                    c   = res[31];
                    amt = a;
                end
            end
            3'd1: res = {20'd0, ins[11:0]};
            3'd2: res = {{6{ins[23]}}, ins, 2'b00};
            3'd3, 3'd4: begin
                res = x;
                a   = (m == 3'd3) ? int'(ins[11:7]) : int'(rs);
                if (m == 3'd3 && a == 0 && ty == 2'd3) begin
                    res = {cin, x[31:1]};
                    c   = x[0];
                end else begin
                    if (m == 3'd3 && a == 0 && (ty == 2'd1 || ty == 2'd2)) a = 32;
                    if (a != 0) begin
                        case (ty)
                            2'd0: begin
                                t = {32'd0, x} << a; res = t[31:0]; c = t[32];
                                amt = (a < 32) ? a : 0;
                            end
                            2'd1: begin
                                t = {x, 32'd0} >> a; res = t[63:32]; c = t[31];
                                amt = (a < 32) ? a : 0;
                            end
                            2'd2: begin
                                t = $signed({x, 32'd0}) >>> a; res = t[63:32]; c = t[31];
                                amt = (a < 32) ? a : 0;
                            end
                            default: begin
                                r = a % 32;
                                if (r == 0) begin
                                    c = x[31];
                                end else begin
                                    t = {x, x} >> r; res = t[31:0]; c = res[31];
                                    amt = r;
                                end
                            end
                        endcase
                    end
                end
            end
            default: begin
                ill = 1'b1;
                c   = 1'b0;
            end
        endcase
        if (!CE) c = 1'b0;
    endfunction

    task automatic issue(input logic [2:0] m, input logic [23:0] ins, input logic [31:0] x,
                         input logic [7:0] rs, input logic cin);
        exp_t e;
        int   n;
        int   amt;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            checks++; errors++;
            $display("FAIL busy_timeout: busy=%0b expected 0", bus.busy);
        end
        bus.mode = m; bus.instr = ins; bus.rm_val = x; bus.rs_val = rs; bus.carry_in = cin;
        bus.start = 1'b1;
        model(m, ins, x, rs, cin, e.res, e.c, e.ill, amt);
        e.lat = 1 + (amt + S - 1) / S;
        e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
        // Scramble inputs so any late sampling would show up
        bus.start    = 1'b0;
        bus.mode     = 3'($urandom);
        bus.instr    = 24'($urandom);
        bus.rm_val   = $urandom;
        bus.rs_val   = 8'($urandom);
        bus.carry_in = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: pending=%0d expected 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus.result_valid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid: result=%h expected no pulse", bus.result);
            end else begin
                e = q.pop_front();
                chk("result",  bus.result, e.res);
                chk("carry",   32'(bus.carry_out), 32'(e.c));
                chk("illegal", 32'(bus.illegal), 32'(e.ill));
                chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.mode = '0; bus.instr = '0; bus.rm_val = '0;
        bus.rs_val = '0; bus.carry_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy",    32'(bus.busy), 32'd0);
        chk("rst_valid",   32'(bus.result_valid), 32'd0);
        chk("rst_result",  bus.result, 32'd0);
        chk("rst_carry",   32'(bus.carry_out), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);

        // Directed cases
        issue(3'd0, 24'h0004FF, 32'h0, 8'h0, 1'b0);
        issue(3'd2, 24'hFFFFFE, 32'h0, 8'h0, 1'b1);
        issue(3'd1, 24'h000ABC, 32'h0, 8'h0, 1'b1);
        issue(3'd3, 24'h000020, 32'h80000000, 8'h0, 1'b0);
        issue(3'd3, 24'h000060, 32'h00000003, 8'h0, 1'b1);
        issue(3'd4, 24'h000040, 32'h80000000, 8'h25, 1'b0);
        issue(3'd4, 24'h000060, 32'h0000000F, 8'd36, 1'b0);
        issue(3'd3, 24'h000000, 32'h12345678, 8'h0, 1'b1);
        issue(3'd4, 24'h000000, 32'h00000001, 8'd32, 1'b1);
        issue(3'd4, 24'h000020, 32'h80000000, 8'd32, 1'b0);
        issue(3'd4, 24'h000020, 32'hFFFFFFFF, 8'd33, 1'b1);
        issue(3'd4, 24'h000060, 32'h80000001, 8'd64, 1'b0);
        drain();

        // ROR #31 with a start pulse during busy, then an illegal op issued in DONE
        issue(3'd3, 24'h000FE0, 32'hA5A5A5A5, 8'h0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 3'd1; bus.instr = 24'h000123;
        @(negedge clk);
        bus.start = 1'b0;
        issue(3'd7, 24'hFFFFFF, 32'hFFFFFFFF, 8'hFF, 1'b1);
        drain();

        // Randomized traffic, back-to-back where the unit allows
        for (int i = 0; i < 200; i++) begin
            logic [2:0] m;
            logic [7:0] rs;
            m  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            rs = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4) * 32) : 8'($urandom);
            issue(m, 24'($urandom), $urandom, rs, 1'($urandom));
        end
        drain();

        // Reset three cycles into a 31-bit shift, after a nonzero result is registered
        issue(3'd0, 24'h0004FF, 32'h0, 8'h0, 1'b1);
        drain();
        @(negedge clk);
        bus.mode = 3'd3; bus.instr = 24'h000FE0; bus.rm_val = 32'hFFFF0001; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy",   32'(bus.busy), 32'd0);
        chk("abort_valid",  32'(bus.result_valid), 32'd0);
        chk("abort_result", bus.result, 32'd0);
        chk("abort_carry",  32'(bus.carry_out), 32'd0);
        repeat (15) @(negedge clk);

        // Operation after the abort behaves normally
        issue(3'd4, 24'h000000, 32'hF000000F, 8'd4, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/extend_shift_unit.md
# extend_shift_unit

Parametrised, multi-cycle successor to the single-cycle immediate extender, sitting in the execute stage between the register file and the ALU operand-B mux. It forms every data-processing/memory/branch operand: rotated 8-bit immediates, 12-bit offsets, branch offsets, and register operands shifted by an immediate or register amount. Shifts are computed by an iterative engine of at most `STEP` bit positions per cycle under a start/busy/valid handshake. The engine also produces an ARM shifter carry-out.

## Interface
- `WIDTH`, 32, datapath width; legal values 32 or 64.
- `STEP`, 4, maximum shift positions per cycle; power of two, 1..`WIDTH`/2.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted on an edge where `busy`=0.
- `mode`  in  3  000 ROT_IMM, 001 IMM12, 010 BRANCH, 011 REG_IMM_SHIFT, 100 REG_REG_SHIFT; 101–111 illegal.
- `instr`  in  24  instruction bits [23:0].
- `rm_val`  in  `WIDTH`  value to shift (modes 011/100).
- `rs_val`  in  8  register shift amount (mode 100).
- `carry_in`  in  1  current C flag.
- `busy`  out  1  high only in SHIFT.
- `result_valid`  out  1  one-cycle pulse in DONE.
- `result`  out  `WIDTH`  extended/shifted operand, registered.
- `carry_out`  out  1  shifter carry.
- `illegal`  out  1  set with `result_valid` for illegal `mode`.

## Operation
- Inputs are sampled only on the accepting edge. Later input changes do not affect the operation in flight.
- States: IDLE, SHIFT, DONE.
  - IDLE/DONE + `start` → operand loaded. Go to SHIFT if effective amount `amt`>0, else DONE.
  - SHIFT: each edge applies `min(rem, STEP)` positions and `rem -= that`. Go to DONE when `rem` reaches 0.
  - DONE: stays one cycle, then IDLE unless `start` is accepted.
- Mode 000: operand `{0, instr[7:0]}`, ROR by `2*instr[11:8]`. `carry_out` = result MSB if amount≠0, else `carry_in`.
- Mode 001: zero-extend `instr[11:0]`; `amt`=0; `carry_out`=`carry_in`.
- Mode 010: sign-extend `{instr[23:0],2'b00}` to `WIDTH`; `amt`=0; `carry_out`=`carry_in`.
- Mode 011: type `instr[6:5]` (LSL, LSR, ASR, ROR), amount `instr[11:7]`.
  - LSL #0 passes `rm_val` with carry `carry_in`.
  - LSR/ASR #0 encode a shift of 32.
  - ROR #0 is RRX: `{carry_in, rm_val[WIDTH-1:1]}`, carry = `rm_val[0]`, `amt`=0.
- Mode 100: type `instr[6:5]`, amount `rs_val`.
  - Amount 0: pass-through, carry `carry_in`.
  - ROR amount is reduced mod `WIDTH`. A nonzero multiple of `WIDTH` gives `result`=`rm_val` with carry = MSB.
- Saturation (resolved at load, `amt`=0):
  - LSL/LSR amount = `WIDTH`: result 0; carry = bit0 (LSL) or MSB (LSR).
  - LSL/LSR amount > `WIDTH`: result 0, carry 0.
  - ASR amount ≥ `WIDTH`: all bits = MSB, carry = MSB.
- Otherwise `carry_out` = last bit shifted out, tracked across iterations.
- Illegal mode: DONE with `result`=0, `carry_out`=0, `illegal`=1.
- `result`, `carry_out` and `illegal` update only on entry to DONE and hold until the next DONE.

## Timing
- Reset values: `busy`=0, `result_valid`=0, `result`=0, `carry_out`=0, `illegal`=0, state IDLE.
- Latency from the accepting edge to `result_valid` high is `1 + ceil(amt/STEP)` cycles. Minimum is 1; maximum is `1 + ceil((WIDTH-1)/STEP)`.
- `start` while `busy`=1 is ignored; no queueing.
- `start` in the DONE cycle is accepted. Back-to-back throughput is one operation per `1 + ceil(amt/STEP)` cycles.
- Reset during SHIFT or DONE: state returns to IDLE next edge, all outputs return to reset values, and no `result_valid` is emitted for the aborted operation.
- Reset has priority over `start` on the same edge.

## Configuration
- `EXTEND_CARRY_EN` defined: carry logic exactly as above.
- `EXTEND_CARRY_EN` undefined:
  - `carry_out` is constant 0.
  - `carry_in` is ignored; RRX shifts in 0.
  - No carry tracking registers are built.
  - `result` and latency are unchanged.

## Test plan
- Mode 000, `instr`=0x0004FF (ROR 8), `STEP`=4 → `result`=0xFF000000, `carry_out`=1, `result_valid` 3 cycles after accept.
- Mode 010, `instr`=0xFFFFFE → `result`=0xFFFFFFF8, latency 1. Mode 001, `instr`=0x000ABC → 0x00000ABC.
- Mode 011 LSR #0, `rm_val`=0x80000000 → `result`=0, `carry_out`=1, latency 1. RRX, `rm_val`=0x00000003, `carry_in`=1 → 0x80000001, `carry_out`=1.
- Mode 100 ASR, `rs_val`=0x25, `rm_val`=0x80000000 → 0xFFFFFFFF, carry 1, latency 1. ROR, `rs_val`=36, `rm_val`=0x0000000F → 0xF0000000, carry 1, latency 2.
- ROR by 31 with `STEP`=4:
  - `start` pulsed while `busy` is ignored; the result arrives at latency 9.
  - A new `start` in the DONE cycle is accepted.
  - Mode 111 → `illegal`=1, `result`=0.
- Reset asserted 3 cycles into a 31-bit shift → no valid pulse; `busy`, `result` and `carry_out` are 0 on the next cycle. Repeat the directed cases with `EXTEND_CARRY_EN` undefined and check `carry_out`=0.
